// File: rtl/s2p_defs.sv
// Shared definitions for the serial-to-parallel deserialiser:
// FSM state encodings and the default word width.
package s2p_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam int unsigned S2P_WIDTH = 8;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Frame input and parallel-word output bundle of the deserialiser.
// slave = deserialiser side, master = feeding/consuming side.
interface serial_to_parallel_if
    import s2p_defs::*;
#(
    parameter int unsigned WIDTH = S2P_WIDTH
);

    logic             start;
    logic             in_valid;
    logic             in_bit;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport slave (
        input  start,
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output out_data,
        output out_valid,
        output busy,
        output overrun
    );

    modport master (
        output start,
        output in_valid,
        output in_bit,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  busy,
        input  overrun
    );

endinterface

// File: rtl/s2p_shift_reg.sv
// WIDTH-bit shift register with enable, fixed direction and sync clear.
// nxt_o exposes the value the register takes on an enabled edge.
module s2p_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] nxt_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // MSB-first: oldest bit walks up to the top.
    if (MSB_FIRST) begin : g_msb
        assign data_d = {data_q[WIDTH-2:0], bit_i};
    end else begin : g_lsb
        assign data_d = {bit_i, data_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign nxt_o  = data_d;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserialiser: collects WIDTH framed serial bits into a word,
// offers it on a valid/ready handshake and flags overrun bits.
module serial_to_parallel
    import s2p_defs::*;
#(
    parameter int unsigned WIDTH     = S2P_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  clear,
    serial_to_parallel_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             shift_en;
    logic [WIDTH-1:0] sr_data;
    logic [WIDTH-1:0] sr_nxt;

    s2p_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .clr_i  (clear),
        .en_i   (shift_en),
        .bit_i  (bus.in_bit),
        .data_o (sr_data),
        .nxt_o  (sr_nxt)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        shift_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                end
            end
            S_RECV: begin
                if (bus.in_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Word leaves via the shifter's next value so the
                        // last bit is included without an extra cycle.
                        out_data_d  = sr_nxt;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = bus.start ? S_RECV : S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == S_RECV);
    assign bus.overrun   = overrun_q;

    logic unused_sr;
    assign unused_sr = ^sr_data;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench: MSB-first and LSB-first instances share stimulus,
// each checked against hand-computed words.
module tb_serial_to_parallel;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic st  = 1'b0;
    logic iv  = 1'b0;
    logic ib  = 1'b0;
    logic rdy = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_to_parallel_if #(.WIDTH(8)) m_if ();
    serial_to_parallel_if #(.WIDTH(8)) l_if ();

    assign m_if.start     = st;
    assign m_if.in_valid  = iv;
    assign m_if.in_bit    = ib;
    assign m_if.out_ready = rdy;
    assign l_if.start     = st;
    assign l_if.in_valid  = iv;
    assign l_if.in_bit    = ib;
    assign l_if.out_ready = rdy;

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .clear (clr),
        .bus   (m_if)
    );

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .clear (clr),
        .bus   (l_if)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag,
                           input logic v, input logic b);
        chk({tag, "/m_valid"}, 32'(m_if.out_valid), 32'(v));
        chk({tag, "/l_valid"}, 32'(l_if.out_valid), 32'(v));
        chk({tag, "/m_busy"},  32'(m_if.busy),      32'(b));
        chk({tag, "/l_busy"},  32'(l_if.busy),      32'(b));
    endtask

    task automatic chk_data(input string tag,
                            input logic [7:0] em,
                            input logic [7:0] el);
        chk({tag, "/m_data"}, 32'(m_if.out_data), 32'(em));
        chk({tag, "/l_data"}, 32'(l_if.out_data), 32'(el));
    endtask

    task automatic chk_ovr(input string tag, input logic e);
        chk({tag, "/m_ovr"}, 32'(m_if.overrun), 32'(e));
        chk({tag, "/l_ovr"}, 32'(l_if.overrun), 32'(e));
    endtask

    // seq[7] goes out first; caller has already opened the frame.
    task automatic send_bits(input string tag, input logic [7:0] seq,
                             input bit gaps, input bit mid_start);
        for (int i = 0; i < 8; i++) begin
            if (mid_start && i == 3) begin
                st = 1'b1;
                iv = 1'b0;
                tick();
                st = 1'b0;
            end
            iv = 1'b1;
            ib = seq[7-i];
            tick();
            if (i < 7) begin
                chk_ctl({tag, "/mid"}, 1'b0, 1'b1);
                if (gaps) begin
                    iv = 1'b0;
                    tick();
                end
            end
        end
        iv = 1'b0;
        chk_ctl({tag, "/done"}, 1'b1, 1'b0);
    endtask

    task automatic open_frame();
        st = 1'b1;
        iv = 1'b0;
        tick();
        st = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        tick();
        clr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st  = 1'($urandom_range(0, 1));
            iv  = 1'($urandom_range(0, 1));
            ib  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            tick();
        end
        chk_ctl("reset", 1'b0, 1'b0);
        chk_data("reset", 8'h00, 8'h00);
        chk_ovr("reset", 1'b0);
        clr = 1'b0;
        st  = 1'b0;
        iv  = 1'b0;
        ib  = 1'b0;
        rdy = 1'b1;
        tick();
        chk_ctl("idle", 1'b0, 1'b0);

        // Basic word, no gaps, ready held high.
        open_frame();
        chk_ctl("b1/start", 1'b0, 1'b1);
        send_bits("b1", 8'hA5, 1'b0, 1'b0);
        chk_data("b1", 8'hA5, 8'hA5);
        tick();
        chk_ctl("b1/hs", 1'b0, 1'b0);
        chk_data("b1/keep", 8'hA5, 8'hA5);

        // Gapped word, distinguishes the two bit orders.
        open_frame();
        send_bits("gap", 8'hC0, 1'b1, 1'b0);
        chk_data("gap", 8'hC0, 8'h03);
        tick();
        chk_ctl("gap/hs", 1'b0, 1'b0);
        chk_ovr("gap", 1'b0);

        // Backpressure with one stray bit in HOLD.
        rdy = 1'b0;
        open_frame();
        send_bits("bp", 8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            iv = (k == 2);
            ib = 1'b1;
            tick();
            chk_ctl("bp/hold", 1'b1, 1'b0);
            chk_data("bp/hold", 8'h3C, 8'h3C);
        end
        iv = 1'b0;
        chk_ovr("bp/set", 1'b1);
        rdy = 1'b1;
        tick();
        chk_ctl("bp/hs", 1'b0, 1'b0);
        chk_ovr("bp/sticky", 1'b1);
        tick();
        tick();
        chk_ovr("bp/sticky2", 1'b1);

        // Back-to-back: start in the handshake cycle.
        rdy = 1'b0;
        open_frame();
        send_bits("b2b1", 8'h4D, 1'b0, 1'b0);
        chk_data("b2b1", 8'h4D, 8'hB2);
        rdy = 1'b1;
        st  = 1'b1;
        tick();
        st = 1'b0;
        chk_ctl("b2b/hs", 1'b0, 1'b1);
        chk_data("b2b/keep", 8'h4D, 8'hB2);
        send_bits("b2b2", 8'hE1, 1'b0, 1'b1);
        chk_data("b2b2", 8'hE1, 8'h87);
        tick();
        chk_ctl("b2b2/hs", 1'b0, 1'b0);

        // Clear mid-frame, then a clean full frame.
        open_frame();
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1;
            ib = ~i[0];
            tick();
        end
        iv  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_ctl("abort", 1'b0, 1'b0);
        chk_data("abort", 8'h00, 8'h00);
        chk_ovr("abort", 1'b0);
        open_frame();
        send_bits("ff", 8'hFF, 1'b0, 1'b0);
        chk_data("ff", 8'hFF, 8'hFF);
        tick();
        chk_ctl("ff/hs", 1'b0, 1'b0);
        chk_ovr("ff", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserialiser stage fed directly by the edge-triggered D flip-flop capture stage. Its `in_bit` is that stage's `q`, and `in_valid` is the sample strobe.
- Collects `WIDTH` serial bits framed by a `start` pulse and presents them as one parallel word.
- Uses a valid/ready output handshake.
- Flags bits that arrive while a completed word is still unconsumed.

Parameters:
- WIDTH, 8, number of bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in `out_data[WIDTH-1]`; 0 = first received bit lands in `out_data[0]`.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- clear  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a frame.
- in_valid  input  1  `in_bit` is valid this cycle.
- in_bit  input  1  serial data bit (`q` of the upstream D flip-flop).
- out_ready  input  1  downstream accepts `out_data`.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  `out_data` holds a complete word.
- busy  output  1  high in RECV state.
- overrun  output  1  sticky error flag.

Behaviour:
- One clock `clk`; reset `clear` is synchronous and active-high. All state updates on the `clk` rising edge.
- Reset (`clear`=1 at an edge):
  - state=IDLE, bit counter=0, shift register=0;
  - `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - `clear` overrides every other input in the same cycle, including mid-frame and mid-HOLD; the partial word is discarded.
- States are IDLE, RECV and HOLD; encoding is 2 bits. `busy`=1 only in RECV.
- IDLE:
  - `start`=1 -> RECV, counter=0.
  - `in_valid` in IDLE is ignored, with no error.
  - If `start` and `in_valid` are both high in the same cycle, that bit is NOT captured; capture begins the following cycle.
- RECV:
  - Each cycle with `in_valid`=1, shift `in_bit` in per MSB_FIRST and increment the counter.
  - Cycles with `in_valid`=0 hold the counter and shift register (gaps are allowed and unbounded).
  - On the cycle `in_valid`=1 with counter=WIDTH-1:
    - load the full word into `out_data`;
    - `out_valid`=1 from the next cycle;
    - counter=0;
    - -> HOLD.
  - Latency: `out_valid` rises exactly one cycle after the last bit is sampled.
  - `start` during RECV is ignored; it does not restart the frame.
- HOLD:
  - `out_valid`=1 and `out_data` is stable until the handshake.
  - `out_valid`&&`out_ready` -> `out_valid`=0 next cycle.
  - Next state after the handshake: RECV if `start`=1 in that same cycle, else IDLE.
  - `out_ready` without `out_valid` has no effect.
  - `in_valid`=1 in HOLD: bit dropped; `overrun` is set to 1 and stays 1 until `clear`.
  - The handshake cycle itself also sets `overrun` if `in_valid`=1 in that cycle.
- `out_data` retains the last word after the handshake; it is updated only on word completion or `clear`.
- Counter width is clog2(WIDTH)+1 bits and never exceeds WIDTH-1 in RECV.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package/header `s2p_defs` holds:
  - state encodings: S_IDLE=2'd0, S_RECV=2'd1, S_HOLD=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the default WIDTH.
- One natural sub-module, `s2p_shift_reg`: a WIDTH-bit shift register with shift-enable, direction (MSB_FIRST) and synchronous clear.
- The FSM, counter, handshake and overrun logic stay in the top-level module.

Test Plan:
- Reset: hold `clear`=1 for 2 cycles with random inputs -> all outputs 0; state IDLE; `busy`=0.
- Basic MSB-first, WIDTH=8:
  - stimulus: `start` pulse, then 8 consecutive `in_valid` bits 1,0,1,0,0,1,0,1, with `out_ready`=1;
  - required: `out_data`=8'hA5 with `out_valid`=1 exactly one cycle after the 8th bit, cleared the next cycle; `busy` high during the 8 bits.
- LSB-first with gaps, MSB_FIRST=0:
  - stimulus: same bit order, `in_valid` deasserted every other cycle;
  - required: `out_data`=8'hA5 bit-reversed = 8'hA5 (palindrome check), then repeat with bits 1,1,0,0,0,0,0,0 -> 8'h03.
- Backpressure/overrun:
  - stimulus: complete a word of 8'h3C with `out_ready`=0 for 5 cycles, pulse `in_valid` once in HOLD;
  - required: `out_data` stays 8'h3C and `out_valid` stays 1; `overrun`=1 and stays 1 after `out_ready`; only `clear` drops it.
- Back-to-back: `start`=1 in the handshake cycle, then 8 bits -> second word captured with no IDLE cycle; `start` pulsed mid-RECV after 3 bits -> frame not restarted, word correct.
- Reset mid-frame: `clear` after 4 of 8 bits, then a full new frame of 8'hFF -> `out_data`=8'hFF with no residue from the aborted bits.
